// File: rtl/rk4_host_link_if.sv
// Byte-level UART side and record-consumer side of the RK4 host link.
// master = the link itself, slave = the uart_tx/uart_rx/consumer side.
interface rk4_host_link_if;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_ti;
    logic [31:0] rec_yi;

    modport master (
        output tx_valid, tx_data, rec_valid, rec_ti, rec_yi,
        input  tx_ready, rx_valid, rx_data, rec_ready
    );

    modport slave (
        input  tx_valid, tx_data, rec_valid, rec_ti, rec_yi,
        output tx_ready, rx_valid, rx_data, rec_ready
    );
endinterface

// File: rtl/rk4_host_link.sv
// Host side of the RK4 solver byte protocol: sends v0y, parses (ti, yi) records into a 2-deep FIFO.
// Optional sequence checking of received records is enabled by defining RK4_HOST_CHECK_EN.
module rk4_host_link #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
    parameter logic [7:0]  MAX_RECORDS    = 8'd127
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           v0y_in,
    output logic                  busy,
    output logic [7:0]            rec_count,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_overflow,
    output logic                  seq_err,
    rk4_host_link_if.master       bus
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RX_TI, S_RX_YI} state_t;

    localparam logic [31:0] END_MARKER = 32'hDEADBEEF;

    state_t      state_q, state_d;
    logic [31:0] v0y_q, v0y_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] ti_q, ti_d;
    logic [31:0] tmo_q, tmo_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        done_q, done_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_overflow_q, err_overflow_d;
    logic [7:0]  rec_count_q, rec_count_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [63:0] fifo_e0_q, fifo_e0_d;
    logic [63:0] fifo_e1_q, fifo_e1_d;
`ifdef RK4_HOST_CHECK_EN
    logic [31:0] prev_ti_q, prev_ti_d;
    logic        have_prev_q, have_prev_d;
    logic        seq_err_q, seq_err_d;
`endif

    logic [31:0] w;
    logic        push, pop, clear_fifo;

    assign w = {bus.rx_data, word_q[31:8]};

    always_comb begin
        state_d        = state_q;
        v0y_d          = v0y_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        ti_d           = ti_q;
        tmo_d          = tmo_q;
        tx_valid_d     = 1'b0;
        tx_data_d      = tx_data_q;
        done_d         = 1'b0;
        err_timeout_d  = err_timeout_q;
        err_overflow_d = err_overflow_q;
        rec_count_d    = rec_count_q;
        fifo_cnt_d     = fifo_cnt_q;
        fifo_e0_d      = fifo_e0_q;
        fifo_e1_d      = fifo_e1_q;
        push           = 1'b0;
        clear_fifo     = 1'b0;
        pop            = (fifo_cnt_q != 2'd0) && bus.rec_ready;
`ifdef RK4_HOST_CHECK_EN
        prev_ti_d      = prev_ti_q;
        have_prev_d    = have_prev_q;
        seq_err_d      = seq_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    v0y_d          = v0y_in;
                    err_timeout_d  = 1'b0;
                    err_overflow_d = 1'b0;
                    rec_count_d    = '0;
                    clear_fifo     = 1'b1;
                    byte_idx_d     = '0;
                    state_d        = S_SEND;
`ifdef RK4_HOST_CHECK_EN
                    have_prev_d    = 1'b0;
                    seq_err_d      = 1'b0;
`endif
                end
            end
            S_SEND: begin
                // Gating on the previous strobe guarantees a gap between bytes.
                if (bus.tx_ready && !tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = v0y_q[{byte_idx_q, 3'b000} +: 8];
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_RX_TI;
                        tmo_d   = '0;
                    end
                end
            end
            S_RX_TI, S_RX_YI: begin
                if (bus.rx_valid) begin
                    tmo_d      = '0;
                    word_d     = w;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (state_q == S_RX_TI) begin
                            if (w == END_MARKER) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                ti_d    = w;
                                state_d = S_RX_YI;
                            end
                        end else begin
                            push        = 1'b1;
                            rec_count_d = (rec_count_q == 8'hFF) ? rec_count_q : rec_count_q + 8'd1;
                            state_d     = S_RX_TI;
                            if (rec_count_d >= MAX_RECORDS) begin
                                err_overflow_d = 1'b1;
                                state_d        = S_IDLE;
                            end
`ifdef RK4_HOST_CHECK_EN
                            if ((have_prev_q ? ($signed(ti_q) <= $signed(prev_ti_q)) : ti_q[31]) || w[31])
                                seq_err_d = 1'b1;
                            prev_ti_d   = ti_q;
                            have_prev_d = 1'b1;
`endif
                        end
                    end
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    err_timeout_d = 1'b1;
                    byte_idx_d    = '0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Two-entry FIFO kept as head/tail registers; pop shifts tail into head.
        if (clear_fifo) begin
            fifo_cnt_d = '0;
        end else if (push && pop) begin
            if (fifo_cnt_q == 2'd1) begin
                fifo_e0_d = {ti_q, w};
            end else begin
                fifo_e0_d = fifo_e1_q;
                fifo_e1_d = {ti_q, w};
            end
        end else if (pop) begin
            fifo_e0_d  = fifo_e1_q;
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end else if (push) begin
            case (fifo_cnt_q)
                2'd0: begin
                    fifo_e0_d  = {ti_q, w};
                    fifo_cnt_d = 2'd1;
                end
                2'd1: begin
                    fifo_e1_d  = {ti_q, w};
                    fifo_cnt_d = 2'd2;
                end
                default: err_overflow_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            v0y_q          <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            ti_q           <= '0;
            tmo_q          <= '0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            done_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            rec_count_q    <= '0;
            fifo_cnt_q     <= '0;
            fifo_e0_q      <= '0;
            fifo_e1_q      <= '0;
`ifdef RK4_HOST_CHECK_EN
            prev_ti_q      <= '0;
            have_prev_q    <= 1'b0;
            seq_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            v0y_q          <= v0y_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            ti_q           <= ti_d;
            tmo_q          <= tmo_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            done_q         <= done_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
            rec_count_q    <= rec_count_d;
            fifo_cnt_q     <= fifo_cnt_d;
            fifo_e0_q      <= fifo_e0_d;
            fifo_e1_q      <= fifo_e1_d;
`ifdef RK4_HOST_CHECK_EN
            prev_ti_q      <= prev_ti_d;
            have_prev_q    <= have_prev_d;
            seq_err_q      <= seq_err_d;
`endif
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign rec_count     = rec_count_q;
    assign done          = done_q;
    assign err_timeout   = err_timeout_q;
    assign err_overflow  = err_overflow_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rec_valid = (fifo_cnt_q != 2'd0);
    assign bus.rec_ti    = fifo_e0_q[63:32];
    assign bus.rec_yi    = fifo_e0_q[31:0];
`ifdef RK4_HOST_CHECK_EN
    assign seq_err       = seq_err_q;
`else
    assign seq_err       = 1'b0;
`endif

endmodule

// File: tb/tb_rk4_host_link.sv
// Directed bench for rk4_host_link: command serialisation, record parsing, FIFO, errors and reset.
module tb_rk4_host_link;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] v0y_in = '0;
    logic        busy, done, err_timeout, err_overflow, seq_err;
    logic [7:0]  rec_count;

    rk4_host_link_if bus();

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_seen[$];
    bit          tx_adj = 1'b0;
    logic        prev_txv = 1'b0;

`ifdef RK4_HOST_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    rk4_host_link #(
        .TIMEOUT_CYCLES(32'd100),
        .MAX_RECORDS   (8'd5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .v0y_in      (v0y_in),
        .busy        (busy),
        .rec_count   (rec_count),
        .done        (done),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow),
        .seq_err     (seq_err),
        .bus         (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: captures tx strobes, counts done pulses, scores popped records.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid) begin
                tx_seen.push_back(bus.tx_data);
                if (prev_txv) tx_adj = 1'b1;
            end
            prev_txv = bus.tx_valid;
            if (done) done_cnt++;
            if (bus.rec_valid && bus.rec_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_rec observed=%0h expected=none", {bus.rec_ti, bus.rec_yi});
                end
                if (exp_q.size() != 0) chk("rec", {bus.rec_ti, bus.rec_yi}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cyc(1);
        bus.rx_valid = 1'b0;
        cyc(1);
    endtask

    task automatic rx_word(input logic [31:0] wd);
        for (int i = 0; i < 4; i++) rx_byte(wd[8*i +: 8]);
    endtask

    task automatic rx_rec(input logic [31:0] ti, input logic [31:0] yi);
        rx_word(ti);
        rx_word(yi);
    endtask

    task automatic do_start(input logic [31:0] v);
        tx_seen.delete();
        tx_adj = 1'b0;
        start  = 1'b1;
        v0y_in = v;
        cyc(1);
        start  = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, input logic [31:0] v);
        for (int i = 0; i < 100 && tx_seen.size() < 4; i++) cyc(1);
        cyc(2);
        chk({tag, "_ntx"}, tx_seen.size(), 64'd4);
        if (tx_seen.size() == 4)
            for (int i = 0; i < 4; i++) chk({tag, "_txbyte"}, tx_seen[i], v[8*i +: 8]);
        chk({tag, "_txadj"}, tx_adj, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        int d0;
        int n;
        bus.tx_ready  = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.rec_ready = 1'b1;
        cyc(3);
        chk("reset_state", {busy, done, bus.tx_valid, bus.rec_valid, err_timeout, err_overflow, seq_err, rec_count}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Command serialisation, then a start while busy must be ignored.
        do_start(32'h0009CCCC);
        wait_cmd("cmd1", 32'h0009CCCC);
        start = 1'b1; v0y_in = 32'hFFFFFFFF;
        cyc(1);
        start = 1'b0;
        cyc(10);
        chk("busy_start_ignored_ntx", tx_seen.size(), 64'd4);
        chk("busy_start_ignored_busy", busy, 1);

        // Single record then end marker.
        d0 = done_cnt;
        exp_q.push_back({32'h0, 32'h00008000});
        rx_rec(32'h0, 32'h00008000);
        rx_word(32'hDEADBEEF);
        cyc(2);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_busy", busy, 0);
        chk("t2_count", rec_count, 1);
        chk("t2_drained", exp_q.size(), 0);

        // FIFO overflow with consumer stalled.
        bus.rec_ready = 1'b0;
        do_start(32'h00010000);
        wait_cmd("cmd3", 32'h00010000);
        chk("t3_err_cleared", err_overflow, 0);
        exp_q.push_back({32'h1, 32'h10});
        exp_q.push_back({32'h2, 32'h20});
        rx_rec(32'h1, 32'h10);
        rx_rec(32'h2, 32'h20);
        chk("t3_no_ovf_yet", err_overflow, 0);
        rx_rec(32'h3, 32'h30);
        chk("t3_ovf", err_overflow, 1);
        chk("t3_count", rec_count, 3);
        chk("t3_head", {bus.rec_valid, bus.rec_ti}, {1'b1, 32'h1});
        chk("t3_busy", busy, 1);
        rx_word(32'hDEADBEEF);
        bus.rec_ready = 1'b1;
        cyc(6);
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_empty", bus.rec_valid, 0);

        // Timeout after a partial ti word.
        d0 = done_cnt;
        do_start(32'h00020000);
        wait_cmd("cmd4", 32'h00020000);
        rx_byte(8'h12);
        rx_byte(8'h34);
        n = 1;
        cyc(49); n += 49;
        chk("t4_no_early_tmo", {err_timeout, busy}, 2'b01);
        while (!err_timeout && n < 300) begin
            cyc(1);
            n++;
        end
        chk("t4_tmo_cycle", n, 100);
        chk("t4_tmo_flags", {err_timeout, busy}, 2'b10);
        chk("t4_no_done", done_cnt - d0, 0);
        do_start(32'h00030000);
        chk("t4_tmo_cleared", err_timeout, 0);
        wait_cmd("cmd4b", 32'h00030000);
        rx_word(32'hDEADBEEF);
        cyc(2);
        chk("t4_busy_after", busy, 0);

        // Reset in the middle of the third yi byte, with a record held in the FIFO.
        bus.rec_ready = 1'b0;
        do_start(32'h00040000);
        wait_cmd("cmd5", 32'h00040000);
        rx_rec(32'h5, 32'h6);
        rx_word(32'h7);
        rx_byte(8'hAA);
        rx_byte(8'hBB);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hCC;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {busy, done, bus.tx_valid, bus.tx_data, bus.rec_valid, err_timeout, err_overflow, seq_err, rec_count}, 0);
        chk("t5_rst_rec", {bus.rec_ti, bus.rec_yi}, 0);
        cyc(1);
        bus.rx_valid = 1'b0;
        bus.rec_ready = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        do_start(32'h11223344);
        wait_cmd("cmd5b", 32'h11223344);
        rx_word(32'hDEADBEEF);
        cyc(2);

        // Sequence check: decreasing ti.
        do_start(32'h00050000);
        wait_cmd("cmd6", 32'h00050000);
        exp_q.push_back({32'h100, 32'h0});
        exp_q.push_back({32'h80, 32'h0});
        rx_rec(32'h100, 32'h0);
        chk("t6_seq_first", seq_err, 0);
        rx_rec(32'h80, 32'h0);
        chk("t6_seq_second", seq_err, SEQ_EXP);
        rx_word(32'hDEADBEEF);
        cyc(2);

        // Record-count limit (MAX_RECORDS = 5) aborts without a marker.
        d0 = done_cnt;
        do_start(32'h00060000);
        chk("t7_seq_cleared", seq_err, 0);
        wait_cmd("cmd7", 32'h00060000);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({i[31:0], 32'h40});
            rx_rec(i[31:0], 32'h40);
        end
        chk("t7_no_ovf_at4", {err_overflow, busy}, 2'b01);
        exp_q.push_back({32'h5, 32'h40});
        rx_rec(32'h5, 32'h40);
        cyc(3);
        chk("t7_ovf_abort", {err_overflow, busy}, 2'b10);
        chk("t7_count", rec_count, 5);
        chk("t7_no_done", done_cnt - d0, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
